// File: rtl/eriscv_lsu_pkg.sv
// Shared types, encodings and helpers for the Eriscv memory stage.
package eriscv_lsu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LD   = 4'd4,
    OP_LBU  = 4'd5,
    OP_LHU  = 4'd6,
    OP_LWU  = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  localparam logic [1:0] CAUSE_LD_MISALIGN = 2'd0;
  localparam logic [1:0] CAUSE_ST_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_LD_FAULT    = 2'd2;
  localparam logic [1:0] CAUSE_ST_FAULT    = 2'd3;

  function automatic logic op_is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic logic op_is_load(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LD) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
  endfunction

  function automatic logic op_is_unsigned(input mem_op_e op);
    return (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
  endfunction

  // Doubleword ops and LWU exist only on a 64-bit datapath.
  function automatic logic op_is_mem(input mem_op_e op, input logic is_64);
    return (op_is_load(op) || op_is_store(op)) &&
           (is_64 || !((op == OP_LD) || (op == OP_SD) || (op == OP_LWU)));
  endfunction

  function automatic mem_size_e op_size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      OP_LW, OP_LWU, OP_SW: return SZ_W;
      default:              return SZ_D;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Store lane shifter / byte-enable generator and load lane extractor / extender.
module lsu_align
  import eriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mem_size_e                    st_size_i,
  input  logic [$clog2(XLEN/8)-1:0]    st_off_i,
  input  logic [XLEN-1:0]              st_data_i,
  output logic [XLEN/8-1:0]            st_be_o,
  output logic [XLEN-1:0]              st_wdata_o,
  input  mem_size_e                    ld_size_i,
  input  logic [$clog2(XLEN/8)-1:0]    ld_off_i,
  input  logic                         ld_unsigned_i,
  input  logic [XLEN-1:0]              ld_rdata_i,
  output logic [XLEN-1:0]              ld_data_o
);

  localparam int unsigned BW = XLEN / 8;

  logic [BW-1:0]   size_mask;
  logic [XLEN-1:0] ld_shifted;
  logic [XLEN-1:0] keep_mask;
  logic            msb;

  // Store side: size mask and data moved up to the addressed byte lane.
  always_comb begin
    size_mask = '0;
    case (st_size_i)
      SZ_B:    size_mask = BW'(8'h01);
      SZ_H:    size_mask = BW'(8'h03);
      SZ_W:    size_mask = BW'(8'h0F);
      default: size_mask = BW'(8'hFF);
    endcase
    st_be_o    = size_mask << st_off_i;
    st_wdata_o = st_data_i << {st_off_i, 3'b000};
  end

  // Load side: bring the lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    keep_mask  = '1;
    msb        = ld_shifted[XLEN-1];
    case (ld_size_i)
      SZ_B: begin
        keep_mask = XLEN'({8{1'b1}});
        msb       = ld_shifted[7];
      end
      SZ_H: begin
        keep_mask = XLEN'({16{1'b1}});
        msb       = ld_shifted[15];
      end
      SZ_W: begin
        keep_mask = XLEN'({32{1'b1}});
        msb       = ld_shifted[31];
      end
      default: begin
        keep_mask = '1;
        msb       = ld_shifted[XLEN-1];
      end
    endcase
    ld_data_o = (ld_shifted & keep_mask) | ((msb & ~ld_unsigned_i) ? ~keep_mask : '0);
  end

endmodule

// File: rtl/mem_lsu.sv
// Eriscv memory stage: register slice for ALU results, req/gnt/rvalid bus master for loads/stores.
module mem_lsu
  import eriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [3:0]            ex_mem_op_i,
  input  logic [REG_ADDR_W-1:0] ex_reg_waddr_i,
  input  logic                  ex_reg_we_i,
  input  logic [XLEN-1:0]       ex_reg_wdata_i,
  input  logic [XLEN-1:0]       ex_store_data_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic                  dmem_we_o,
  output logic [XLEN/8-1:0]     dmem_be_o,
  output logic [XLEN-1:0]       dmem_addr_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  input  logic                  dmem_err_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_reg_waddr_o,
  output logic                  wb_reg_we_o,
  output logic [XLEN-1:0]       wb_reg_wdata_o,
  output logic                  exc_valid_o,
  output logic [1:0]            exc_cause_o,
  output logic [XLEN-1:0]       exc_addr_o
);

  localparam int unsigned BW    = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BW);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic        IS_64 = (XLEN == 64);

  lsu_state_e            state_q;
  mem_op_e               op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  we_q;
  logic [XLEN-1:0]       addr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  dmem_req_q;
  logic                  dmem_we_q;
  logic [BW-1:0]         dmem_be_q;
  logic [XLEN-1:0]       dmem_addr_q;
  logic [XLEN-1:0]       dmem_wdata_q;
  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_reg_waddr_q;
  logic                  wb_reg_we_q;
  logic [XLEN-1:0]       wb_reg_wdata_q;
  logic                  exc_valid_q;
  logic [1:0]            exc_cause_q;
  logic [XLEN-1:0]       exc_addr_q;

  mem_op_e         ex_op;
  logic            ex_is_mem;
  logic            ex_is_store;
  logic            ex_misal;
  logic [BW-1:0]   al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ld_data;
  logic            op_q_store;

  assign ex_op       = mem_op_e'(ex_mem_op_i);
  assign ex_is_mem   = op_is_mem(ex_op, IS_64);
  assign ex_is_store = op_is_store(ex_op);
  assign ex_misal    = is_misaligned(op_size(ex_op), ex_reg_wdata_i[2:0]);
  assign op_q_store  = op_is_store(op_q);

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .st_size_i     (op_size(ex_op)),
    .st_off_i      (ex_reg_wdata_i[OFFW-1:0]),
    .st_data_i     (ex_store_data_i),
    .st_be_o       (al_be),
    .st_wdata_o    (al_wdata),
    .ld_size_i     (op_size(op_q)),
    .ld_off_i      (addr_q[OFFW-1:0]),
    .ld_unsigned_i (op_is_unsigned(op_q)),
    .ld_rdata_i    (dmem_rdata_i),
    .ld_data_o     (al_ld_data)
  );

  // Stage FSM: accept in IDLE, hold the bus request in REQ, collect the response in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_NONE;
      rd_q           <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      cnt_q          <= '0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_be_q      <= '0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_waddr_q <= '0;
      wb_reg_we_q    <= 1'b0;
      wb_reg_wdata_q <= '0;
      exc_valid_q    <= 1'b0;
      exc_cause_q    <= '0;
      exc_addr_q     <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ex_valid_i) begin
            if (!ex_is_mem) begin
              wb_valid_q     <= 1'b1;
              wb_reg_waddr_q <= ex_reg_waddr_i;
              wb_reg_we_q    <= ex_reg_we_i;
              wb_reg_wdata_q <= ex_reg_wdata_i;
            end else if (ex_misal) begin
              wb_valid_q     <= 1'b1;
              wb_reg_waddr_q <= ex_reg_waddr_i;
              wb_reg_we_q    <= 1'b0;
              exc_valid_q    <= 1'b1;
              exc_cause_q    <= ex_is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
              exc_addr_q     <= ex_reg_wdata_i;
            end else begin
              op_q         <= ex_op;
              rd_q         <= ex_reg_waddr_i;
              we_q         <= ex_reg_we_i;
              addr_q       <= ex_reg_wdata_i;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= ex_is_store;
              dmem_be_q    <= al_be;
              dmem_addr_q  <= {ex_reg_wdata_i[XLEN-1:OFFW], {OFFW{1'b0}}};
              dmem_wdata_q <= al_wdata;
              state_q      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid_i || (cnt_q == CNT_W'(MAX_WAIT - 1))) begin
            state_q        <= ST_IDLE;
            wb_valid_q     <= 1'b1;
            wb_reg_waddr_q <= rd_q;
            if (!dmem_rvalid_i || dmem_err_i) begin
              // Bus error and response timeout raise the same access fault.
              wb_reg_we_q <= 1'b0;
              exc_valid_q <= 1'b1;
              exc_cause_q <= op_q_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
              exc_addr_q  <= addr_q;
            end else if (op_q_store) begin
              wb_reg_we_q <= 1'b0;
            end else begin
              wb_reg_we_q    <= we_q;
              wb_reg_wdata_q <= al_ld_data;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ex_ready_o     = (state_q == ST_IDLE);
  assign dmem_req_o     = dmem_req_q;
  assign dmem_we_o      = dmem_we_q;
  assign dmem_be_o      = dmem_be_q;
  assign dmem_addr_o    = dmem_addr_q;
  assign dmem_wdata_o   = dmem_wdata_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_reg_waddr_o = wb_reg_waddr_q;
  assign wb_reg_we_o    = wb_reg_we_q;
  assign wb_reg_wdata_o = wb_reg_wdata_q;
  assign exc_valid_o    = exc_valid_q;
  assign exc_cause_o    = exc_cause_q;
  assign exc_addr_o     = exc_addr_q;

endmodule
